// File: rtl/imem_boot_loader.sv
// Boot-time loader: streams instruction words into the instruction memory write
// port, verifies an additive checksum, and only then releases the core.
module imem_boot_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          LEN_W     = 16,
    parameter int          TIMEOUT   = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_start_i,
    input  logic [LEN_W-1:0] load_len_i,
    input  logic [31:0]      exp_sum_i,
    input  logic             s_valid_i,
    input  logic [31:0]      s_data_i,
    output logic             s_ready_o,
    output logic             wr_en_imem_o,
    output logic [31:0]      wr_addr_imem_o,
    output logic [31:0]      wr_instr_imem_o,
    output logic             core_run_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [1:0]       err_code_o,
    output logic [2:0]       state_o
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_CHECK = 3'd2;
    localparam logic [2:0] ST_RUN   = 3'd3;
    localparam logic [2:0] ST_ERR   = 3'd4;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_SUM  = 2'd1;
    localparam logic [1:0] ERR_TMO  = 2'd2;
    localparam logic [1:0] ERR_ZLEN = 2'd3;

    // Idle counter only ever needs to reach TIMEOUT-1.
    localparam int               TMO_W    = $clog2(TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    logic [2:0]       state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [31:0]      exp_sum_q, exp_sum_d;
    logic [LEN_W-1:0] idx_q, idx_d;
    logic [31:0]      sum_q, sum_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [1:0]       err_code_q, err_code_d;
    logic             wr_en_q, wr_en_d;
    logic [31:0]      wr_addr_q, wr_addr_d;
    logic [31:0]      wr_data_q, wr_data_d;
    logic             beat;

    // Handshake: a word transfers on a rising edge where s_valid_i and s_ready_o
    // are both high; s_ready_o is a pure decode of the LOAD state, so the
    // producer may hold s_valid_i/s_data_i stable for as long as it likes.
    assign s_ready_o = (state_q == ST_LOAD);
    assign beat      = s_valid_i & s_ready_o;

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        exp_sum_d  = exp_sum_q;
        idx_d      = idx_q;
        sum_d      = sum_q;
        tmo_d      = tmo_q;
        err_code_d = err_code_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        case (state_q)
            ST_IDLE, ST_RUN, ST_ERR: begin
                if (load_start_i) begin
                    len_d      = load_len_i;
                    exp_sum_d  = exp_sum_i;
                    idx_d      = '0;
                    sum_d      = '0;
                    tmo_d      = '0;
                    err_code_d = ERR_NONE;
                    if (load_len_i == '0) begin
                        state_d    = ST_ERR;
                        err_code_d = ERR_ZLEN;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (beat) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = BASE_ADDR + (32'(idx_q) << 2);
                    wr_data_d = s_data_i;
                    sum_d     = sum_q + s_data_i;
                    idx_d     = idx_q + LEN_W'(1);
                    tmo_d     = '0;
                    if (idx_q == len_q - LEN_W'(1)) begin
                        state_d = ST_CHECK;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d    = ST_ERR;
                    err_code_d = ERR_TMO;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_CHECK: begin
                // The last word's write lands in memory during this cycle.
                if (sum_q == exp_sum_q) begin
                    state_d = ST_RUN;
                end else begin
                    state_d    = ST_ERR;
                    err_code_d = ERR_SUM;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            exp_sum_q  <= '0;
            idx_q      <= '0;
            sum_q      <= '0;
            tmo_q      <= '0;
            err_code_q <= ERR_NONE;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            exp_sum_q  <= exp_sum_d;
            idx_q      <= idx_d;
            sum_q      <= sum_d;
            tmo_q      <= tmo_d;
            err_code_q <= err_code_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    assign wr_en_imem_o    = wr_en_q;
    assign wr_addr_imem_o  = wr_addr_q;
    assign wr_instr_imem_o = wr_data_q;
    assign core_run_o      = (state_q == ST_RUN);
    assign busy_o          = (state_q == ST_LOAD) || (state_q == ST_CHECK);
    assign done_o          = (state_q == ST_RUN);
    assign err_o           = (state_q == ST_ERR);
    assign err_code_o      = err_code_q;
    assign state_o         = state_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Randomized bench for imem_boot_loader against a transaction-level model of the
// load: expected writes, final outcome and timing are derived per load.
module tb_imem_boot_loader;

    localparam int          TMO   = 16;
    localparam int          LEN_W = 16;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic             clk;
    logic             reset;
    logic             load_start;
    logic [LEN_W-1:0] load_len;
    logic [31:0]      exp_sum;
    logic             s_valid;
    logic [31:0]      s_data;
    logic             s_ready_o;
    logic             wr_en_imem_o;
    logic [31:0]      wr_addr_imem_o;
    logic [31:0]      wr_instr_imem_o;
    logic             core_run_o;
    logic             busy_o;
    logic             done_o;
    logic             err_o;
    logic [1:0]       err_code_o;
    logic [2:0]       state_o;

    imem_boot_loader #(
        .BASE_ADDR(BASE),
        .LEN_W    (LEN_W),
        .TIMEOUT  (TMO)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .load_start_i   (load_start),
        .load_len_i     (load_len),
        .exp_sum_i      (exp_sum),
        .s_valid_i      (s_valid),
        .s_data_i       (s_data),
        .s_ready_o      (s_ready_o),
        .wr_en_imem_o   (wr_en_imem_o),
        .wr_addr_imem_o (wr_addr_imem_o),
        .wr_instr_imem_o(wr_instr_imem_o),
        .core_run_o     (core_run_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .err_o          (err_o),
        .err_code_o     (err_code_o),
        .state_o        (state_o)
    );

    // clock / cycle counter
    int cyc = 0;
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    // scoreboard entries: {cycle the write is visible, address, data}
    logic [95:0] exp_q[$];

    logic [31:0] words_a[16];
    int          gaps_a[16];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, want, $time);
    endtask

    always @(negedge clk) begin
        logic [95:0] e;
        if (reset && wr_en_imem_o) begin
            if (exp_q.size() == 0) begin
                check("wr_unexpected", 32'(wr_en_imem_o), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("wr_cycle", 32'(cyc), e[95:64]);
                check("wr_addr", wr_addr_imem_o, e[63:32]);
                check("wr_data", wr_instr_imem_o, e[31:0]);
            end
        end
    end

    // One load: n words offered (gaps_a[i] idle cycles before word i). The model
    // decides acceptance, timeout and checksum outcome from the rules directly.
    task automatic do_load(input int len, input int n, input logic [31:0] esum);
        int          s_cyc;
        int          gsum;
        logic [31:0] sum;
        bit          tmo;
        @(posedge clk); #1;
        load_start = 1'b1;
        load_len   = LEN_W'(len);
        exp_sum    = esum;
        @(posedge clk); #1;
        load_start = 1'b0;
        s_cyc = cyc;
        check("run_drop", 32'(core_run_o), 32'd0);
        if (len == 0) begin
            check("zl_err", 32'(err_o), 32'd1);
            check("zl_code", 32'(err_code_o), 32'd3);
            check("zl_busy", 32'(busy_o), 32'd0);
            repeat (2) @(posedge clk);
            #1 check("zl_nowr", 32'(exp_q.size()), 32'd0);
            return;
        end
        check("load_ready", 32'(s_ready_o), 32'd1);
        check("load_code", 32'(err_code_o), 32'd0);
        sum  = '0;
        gsum = 0;
        tmo  = 1'b0;
        for (int i = 0; i < len && !tmo; i++) begin
            int g;
            g = (i < n) ? gaps_a[i] : TMO + 3;
            if (g >= TMO) begin
                repeat (TMO - 1) begin @(posedge clk); #1; end
                check("tmo_pre_busy", 32'(busy_o), 32'd1);
                check("tmo_pre_err", 32'(err_o), 32'd0);
                @(posedge clk); #1;
                check("tmo_err", 32'(err_o), 32'd1);
                check("tmo_code", 32'(err_code_o), 32'd2);
                check("tmo_ready", 32'(s_ready_o), 32'd0);
                check("tmo_run", 32'(core_run_o), 32'd0);
                tmo = 1'b1;
            end else begin
                repeat (g) begin
                    @(posedge clk); #1;
                    check("gap_ready", 32'(s_ready_o), 32'd1);
                end
                gsum += g;
                s_valid = 1'b1;
                s_data  = words_a[i];
                @(posedge clk); #1;
                s_valid = 1'b0;
                s_data  = $urandom;
                exp_q.push_back({32'(cyc), BASE + 32'(i) * 32'd4, words_a[i]});
                sum += words_a[i];
                if (i < len - 1) check("beat_ready", 32'(s_ready_o), 32'd1);
                else begin
                    check("chk_ready", 32'(s_ready_o), 32'd0);
                    check("chk_busy", 32'(busy_o), 32'd1);
                    check("chk_run", 32'(core_run_o), 32'd0);
                end
            end
        end
        if (!tmo) begin
            @(posedge clk); #1;
            if (sum == esum) begin
                check("run_core", 32'(core_run_o), 32'd1);
                check("run_done", 32'(done_o), 32'd1);
                check("run_code", 32'(err_code_o), 32'd0);
                check("run_latency", 32'(cyc - s_cyc), 32'(len + gsum + 1));
            end else begin
                check("sum_err", 32'(err_o), 32'd1);
                check("sum_code", 32'(err_code_o), 32'd1);
                check("sum_run", 32'(core_run_o), 32'd0);
            end
        end
        repeat (2) @(posedge clk);
        #1 check("wr_drained", 32'(exp_q.size()), 32'd0);
        check("end_ready", 32'(s_ready_o), 32'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] s;
        int          len;
        int          n;
        reset      = 1'b0;
        load_start = 1'b0;
        load_len   = '0;
        exp_sum    = '0;
        s_valid    = 1'b0;
        s_data     = '0;
        #1;
        check("rst_core", 32'(core_run_o), 32'd0);
        check("rst_wr_en", 32'(wr_en_imem_o), 32'd0);
        check("rst_flags", {28'd0, s_ready_o, busy_o, done_o, err_o}, 32'd0);
        check("rst_code", 32'(err_code_o), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // nominal image
        words_a[0] = 32'h2008_0005;
        words_a[1] = 32'h2009_0007;
        words_a[2] = 32'h0109_5020;
        for (int i = 0; i < 16; i++) gaps_a[i] = 0;
        do_load(3, 3, words_a[0] + words_a[1] + words_a[2]);
        // checksum mismatch
        do_load(3, 3, 32'h0);
        // gap of 10 cycles before the second word
        gaps_a[1] = 10;
        do_load(2, 2, words_a[0] + words_a[1]);
        // reload from RUN, one beat only -> stream timeout
        gaps_a[1] = 0;
        do_load(2, 1, 32'h0);
        // zero length, then a single-word image
        do_load(0, 0, 32'h0);
        words_a[0] = 32'h0000_0001;
        do_load(1, 1, 32'h0000_0001);

        for (int it = 0; it < 24; it++) begin
            len = $urandom_range(1, 6);
            n   = ($urandom_range(0, 4) == 0) ? $urandom_range(0, len - 1) : len;
            s   = '0;
            for (int i = 0; i < len; i++) begin
                int r;
                words_a[i] = $urandom;
                s += words_a[i];
                r = $urandom_range(0, 11);
                gaps_a[i] = (r < 8) ? $urandom_range(0, 3) : (r < 10) ? TMO - 1 : TMO;
            end
            do_load(len, n, ($urandom_range(0, 3) == 0) ? s ^ 32'h0000_0100 : s);
        end

        // reset in the middle of a load
        words_a[0] = 32'hdead_beef;
        @(posedge clk); #1;
        load_start = 1'b1;
        load_len   = LEN_W'(4);
        exp_sum    = 32'h0;
        @(posedge clk); #1;
        load_start = 1'b0;
        s_valid    = 1'b1;
        s_data     = words_a[0];
        @(posedge clk); #1;
        s_valid = 1'b0;
        exp_q.push_back({32'(cyc), BASE, words_a[0]});
        @(posedge clk); #2;
        check("mid_busy", 32'(busy_o), 32'd1);
        reset = 1'b0;
        #1;
        check("mid_rst_flags", {28'd0, s_ready_o, busy_o, done_o, err_o}, 32'd0);
        check("mid_rst_wr", {wr_addr_imem_o[30:0], wr_en_imem_o}, 32'd0);
        check("mid_rst_data", wr_instr_imem_o, 32'd0);
        check("mid_rst_core", 32'(core_run_o), 32'd0);
        check("mid_rst_code", 32'(err_code_o), 32'd0);
        check("mid_rst_state", 32'(state_o), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        check("mid_rst_drained", 32'(exp_q.size()), 32'd0);

        words_a[0] = 32'h1234_5678;
        words_a[1] = 32'h0fed_cba9;
        gaps_a[0]  = 1;
        gaps_a[1]  = 0;
        do_load(2, 2, words_a[0] + words_a[1]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
